// File: rtl/seg7_reader_if.sv
// seg7_reader_if: segment bus in, decoded digit and status out.
//   seg_in      segment bus (bit0=a .. bit6=g), active high
//   valid_out   one-cycle pulse on a newly accepted digit
//   digit_out   last accepted digit, held between accepts
//   invalid_out one-cycle pulse on a stable pattern outside the decode table
//   seq_err     one-cycle pulse, with valid_out, on an out-of-sequence digit
//   period_out  cycles between the last two digit accepts
//   stall       level; period counter saturated since the last accept
// master drives seg_in (display source / bench), slave is the reader.
interface seg7_reader_if #(
   parameter int unsigned PERIOD_W = 24
);
   logic [6:0]          seg_in;
   logic                valid_out;
   logic [3:0]          digit_out;
   logic                invalid_out;
   logic                seq_err;
   logic [PERIOD_W-1:0] period_out;
   logic                stall;

   modport master (
      output seg_in,
      input  valid_out, digit_out, invalid_out, seq_err, period_out, stall
   );

   modport slave (
      input  seg_in,
      output valid_out, digit_out, invalid_out, seq_err, period_out, stall
   );
endinterface

// File: rtl/seg7_reader.sv
// seg7_reader: deglitches a 7-segment bus, decodes it back to a digit,
// checks the counter wrap sequence and measures the period between digits.
// Ports: clk, rst (synchronous, active high), bus (seg7_reader_if.slave).
// Optional: define SEG7_READER_HEX_EN to decode A-F patterns as digits 10-15.
module seg7_reader #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned MAX_DIGIT     = 6,
   parameter int unsigned PERIOD_W      = 24
) (
   input  logic          clk,
   input  logic          rst,
   seg7_reader_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [PERIOD_W-1:0] PER_MAX  = '1;
   localparam logic [3:0]          DIG_MAX  = 4'(MAX_DIGIT);

   typedef enum logic {IDLE, TRACK} state_t;

   state_t              state_q, state_d;
   logic [6:0]          seg_q;
   logic [6:0]          last_pat_q, last_pat_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PERIOD_W-1:0] per_q, per_d, period_d;
   logic                valid_d, invalid_d, seq_err_d, stall_d;
   logic [3:0]          digit_d;
   logic                stable_c, accept_c, hit_c, table_acc_c;
   logic [3:0]          dec_c, expect_c;
   logic [4:0]          lookup_c;

   // Pattern to {hit, digit}; hit=0 for blank and unknown patterns.
   function automatic logic [4:0] decode(input logic [6:0] p);
      logic [4:0] r;
      case (p)
         7'h3F: r = {1'b1, 4'd0};
         7'h06: r = {1'b1, 4'd1};
         7'h5B: r = {1'b1, 4'd2};
         7'h4F: r = {1'b1, 4'd3};
         7'h66: r = {1'b1, 4'd4};
         7'h6D: r = {1'b1, 4'd5};
         7'h7D: r = {1'b1, 4'd6};
         7'h07: r = {1'b1, 4'd7};
         7'h7F: r = {1'b1, 4'd8};
         7'h6F: r = {1'b1, 4'd9};
`ifdef SEG7_READER_HEX_EN
         7'h77: r = {1'b1, 4'd10};
         7'h7C: r = {1'b1, 4'd11};
         7'h39: r = {1'b1, 4'd12};
         7'h5E: r = {1'b1, 4'd13};
         7'h79: r = {1'b1, 4'd14};
         7'h71: r = {1'b1, 4'd15};
`endif
         default: r = 5'd0;
      endcase
      return r;
   endfunction

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         seg_q           <= '0;
         cnt_q           <= '0;
         last_pat_q      <= '0;
         per_q           <= '0;
         bus.valid_out   <= 1'b0;
         bus.digit_out   <= '0;
         bus.invalid_out <= 1'b0;
         bus.seq_err     <= 1'b0;
         bus.period_out  <= '0;
         bus.stall       <= 1'b0;
      end else begin
         state_q         <= state_d;
         seg_q           <= bus.seg_in;
         cnt_q           <= cnt_d;
         last_pat_q      <= last_pat_d;
         per_q           <= per_d;
         bus.valid_out   <= valid_d;
         bus.digit_out   <= digit_d;
         bus.invalid_out <= invalid_d;
         bus.seq_err     <= seq_err_d;
         bus.period_out  <= period_d;
         bus.stall       <= stall_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      last_pat_d = last_pat_q;
      valid_d    = 1'b0;
      invalid_d  = 1'b0;
      seq_err_d  = 1'b0;
      digit_d    = bus.digit_out;
      period_d   = bus.period_out;

      stable_c = (bus.seg_in == seg_q);
      if (!stable_c)             cnt_d = '0;
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      else                       cnt_d = cnt_q;

      // Accept on the edge where the stability count reaches its limit, so
      // the result is registered STABLE_CYCLES edges after the first sample.
      accept_c    = stable_c && (cnt_q == CNT_LAST) && (seg_q != last_pat_q);
      lookup_c    = decode(seg_q);
      hit_c       = lookup_c[4];
      dec_c       = lookup_c[3:0];
      table_acc_c = accept_c && hit_c;
      expect_c    = (bus.digit_out == DIG_MAX) ? 4'd0 : bus.digit_out + 4'd1;

      if (table_acc_c)          per_d = '0;
      else if (per_q != PER_MAX) per_d = per_q + PERIOD_W'(1);
      else                      per_d = per_q;

      if (accept_c) begin
         last_pat_d = seg_q;
         if (seg_q != 7'h00 && !hit_c) invalid_d = 1'b1;
      end

      if (table_acc_c) begin
         valid_d = 1'b1;
         digit_d = dec_c;
         case (state_q)
            IDLE: state_d = TRACK;
            TRACK: begin
               seq_err_d = (dec_c != expect_c) || (dec_c > DIG_MAX);
               // per_q counts from 0 on the accept edge, hence the +1.
               period_d  = (per_q == PER_MAX) ? PER_MAX : per_q + PERIOD_W'(1);
            end
            default: state_d = IDLE;
         endcase
      end

      stall_d = (per_d == PER_MAX);
   end
endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: randomized bench for seg7_reader against an edge-counting
// reference model (run start / accept edge bookkeeping, table lookup).
module tb_seg7_reader;
   localparam int unsigned STABLE = 4;
   localparam int unsigned MAXD   = 6;
   localparam int unsigned PW     = 8;
   localparam int          PMAX   = (1 << PW) - 1;
`ifdef SEG7_READER_HEX_EN
   localparam int NDIG = 16;
`else
   localparam int NDIG = 10;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seg7_reader_if #(.PERIOD_W(PW)) bus ();

   seg7_reader #(
      .STABLE_CYCLES(STABLE),
      .MAX_DIGIT    (MAXD),
      .PERIOD_W     (PW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                            7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E,
                            7'h79, 7'h71};

   int n_vec = 0;
   int n_err = 0;
   int n_valid_seen, n_inv_seen, n_seq_seen;

   // Reference model state.
   int         edge_n = 0, run_start = 0, last_acc = 0;
   logic [6:0] prev_in = '0, m_last_pat = '0;
   logic       m_track = 1'b0;
   int         m_digit = 0, m_period = 0;
   logic       m_valid, m_invalid, m_seq, m_stall;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, got, exp, edge_n, $time);
      end
   endtask

   function automatic int lookup(input logic [6:0] p);
      for (int i = 0; i < NDIG; i++) if (tbl[i] == p) return i;
      return -1;
   endfunction

   task automatic model_edge(input logic [6:0] in, input logic r);
      int d;
      edge_n++;
      m_valid = 1'b0; m_invalid = 1'b0; m_seq = 1'b0;
      if (r) begin
         prev_in = '0; run_start = edge_n; m_last_pat = '0; m_track = 1'b0;
         m_digit = 0; m_period = 0; last_acc = edge_n; m_stall = 1'b0;
         return;
      end
      if (in != prev_in) begin
         run_start = edge_n;
         prev_in   = in;
      end
      if (edge_n - run_start == int'(STABLE) && in != m_last_pat) begin
         m_last_pat = in;
         d = lookup(in);
         if (in != 7'h00 && d < 0) m_invalid = 1'b1;
         if (d >= 0) begin
            m_valid = 1'b1;
            if (m_track) begin
               m_seq    = (d != ((m_digit == int'(MAXD)) ? 0 : m_digit + 1)) || (d > int'(MAXD));
               m_period = (edge_n - last_acc > PMAX) ? PMAX : edge_n - last_acc;
            end
            m_track  = 1'b1;
            m_digit  = d;
            last_acc = edge_n;
         end
      end
      m_stall = (edge_n - last_acc) >= PMAX;
   endtask

   // One clock: drive, let the DUT see the edge, advance the model, compare.
   task automatic step(input logic [6:0] s, input logic r);
      bus.seg_in = s;
      rst        = r;
      @(posedge clk);
      model_edge(s, r);
      #1;
      check("valid_out",   32'(bus.valid_out),   32'(m_valid));
      check("invalid_out", 32'(bus.invalid_out), 32'(m_invalid));
      check("seq_err",     32'(bus.seq_err),     32'(m_seq));
      check("digit_out",   32'(bus.digit_out),   32'(m_digit));
      check("period_out",  32'(bus.period_out),  32'(m_period));
      check("stall",       32'(bus.stall),       32'(m_stall));
      if (bus.valid_out)   n_valid_seen++;
      if (bus.invalid_out) n_inv_seen++;
      if (bus.seq_err)     n_seq_seen++;
   endtask

   task automatic hold(input logic [6:0] s, input int n);
      for (int i = 0; i < n; i++) step(s, 1'b0);
   endtask

   task automatic clear_counts();
      n_valid_seen = 0; n_inv_seen = 0; n_seq_seen = 0;
   endtask

   initial begin
      logic [6:0] pat;
      int         sel;
      bus.seg_in = '0;

      // Reset, then a single digit 0 held.
      step(7'h00, 1'b1);
      step(7'h00, 1'b1);
      clear_counts();
      hold(7'h3F, 10);
      check("first_accepts", 32'(n_valid_seen), 32'd1);

      // Full wrap sequence 0..6,0, each held 100 cycles.
      step(7'h00, 1'b1);
      clear_counts();
      for (int d = 0; d <= int'(MAXD); d++) hold(tbl[d], 100);
      hold(tbl[0], 100);
      check("wrap_accepts", 32'(n_valid_seen), 32'd8);
      check("wrap_seq_err", 32'(n_seq_seen), 32'd0);

      // Short glitches returning to the held pattern are ignored.
      clear_counts();
      for (int i = 0; i < 20; i++) begin
         hold(7'($urandom_range(1, 127)), int'($urandom_range(1, STABLE - 1)));
         hold(tbl[0], int'($urandom_range(STABLE, 10)));
      end
      check("glitch_accepts", 32'(n_valid_seen + n_inv_seen), 32'd0);

      // Out-of-sequence digit, resync, and the hex 'A' pattern.
      hold(tbl[2], 20);
      hold(tbl[5], 20);
      hold(tbl[6], 20);
      hold(7'h77, 20);

      // Randomized mix of in-sequence digits, jumps, blanks and junk.
      for (int i = 0; i < 1500; i++) begin
         sel = int'($urandom_range(0, 99));
         if (sel < 50)      pat = tbl[(m_digit >= int'(MAXD)) ? 0 : m_digit + 1];
         else if (sel < 75) pat = tbl[$urandom_range(0, 15)];
         else if (sel < 85) pat = 7'h00;
         else               pat = 7'($urandom_range(0, 127));
         if ($urandom_range(0, 99) == 0) step(pat, 1'b1);
         hold(pat, int'($urandom_range(1, 12)));
      end

      // Stall: one digit held past counter saturation, then reset mid-hold.
      hold(tbl[1], 300);
      hold(tbl[2], 20);
      hold(tbl[3], 10);
      step(tbl[3], 1'b1);
      step(tbl[3], 1'b1);
      clear_counts();
      hold(tbl[3], 10);
      check("rst_reaccept", 32'(n_valid_seen), 32'd1);
      check("rst_seq_err",  32'(n_seq_seen),   32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/seg7_reader.md
# seg7_reader

Recovers the displayed digit from a 7-segment drive bus, the receiving end of the team's counter-to-seg7 display path. Deglitches the segment pattern, decodes it back to a 4-bit value and checks that successive digits follow the counter's wrap sequence. Measures the number of cycles between digit changes and flags stalls. Sits on a tile's dedicated inputs, for loopback self-test of a display design or for monitoring another tile's display.

## Interface
- STABLE_CYCLES, 4: cycles a pattern must stay constant before it is accepted; legal range ≥2.
- MAX_DIGIT, 6: last digit of the expected sequence before it wraps to 0.
- PERIOD_W, 24: width of the period counter.

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- seg_in  in  7  segment bus; bit0=a … bit6=g; active high
- valid_out  out  1  one-cycle pulse when a new digit is accepted
- digit_out  out  4  last accepted digit; held between accepts
- invalid_out  out  1  one-cycle pulse when a stable pattern is not in the decode table
- seq_err  out  1  one-cycle pulse with valid_out when the digit is not the expected successor
- period_out  out  PERIOD_W  cycles between the last two accepts
- stall  out  1  level; period counter has saturated since the last accept

## Operation
- Decode table: 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9. 0x00 is blank.
- Stabilizer: seg_q <= seg_in every cycle.
  - cnt clears when seg_in != seg_q.
  - Otherwise cnt increments and saturates at STABLE_CYCLES.
- Accept event: cnt reaches STABLE_CYCLES while seg_q != last_pat. At most one accept per stable run. On every accept, last_pat <= seg_q.
- Blank accept: no pulses; no state change beyond last_pat.
- Non-table accept: invalid_out pulses. digit_out, FSM state and period counter are unchanged.
- Table accept: valid_out pulses and digit_out is updated.
- FSM states:
  - IDLE: first table accept → no seq_err, no period_out update → go to TRACK.
  - TRACK: expected digit = (last == MAX_DIGIT) ? 0 : last+1. On mismatch, seq_err pulses and tracking resyncs to the new digit. period_out <= period counter on each accept.
- Period counter:
  - Clears on each table accept.
  - Otherwise increments, saturating at all-ones.
  - stall = counter saturated; stall clears on the next table accept.
- Digits above MAX_DIGIT always raise seq_err in TRACK.

## Timing
- Reset values:
  - Outputs: valid_out=0, digit_out=0, invalid_out=0, seq_err=0, period_out=0, stall=0.
  - Internal: FSM=IDLE, seg_q=0, cnt=0, last_pat=0x00, period counter=0.
- Pattern P first present at edge k and held → valid_out/invalid_out/digit_out/seq_err are registered at edge k+STABLE_CYCLES.
- All pulses are exactly one cycle wide and registered; there are no combinational outputs.
- A change lasting fewer than STABLE_CYCLES edges is ignored.
- A return to last_pat after a glitch produces no accept.
- period_out for accepts at edges a and b = b−a; saturates at 2^PERIOD_W−1.
- rst asserted mid-operation: everything returns to reset values at that edge. A currently held pattern is re-accepted as the first (IDLE) digit STABLE_CYCLES edges after reset release.

## Configuration
- Macro SEG7_READER_HEX_EN.
- Defined: additional table entries 0x77→10, 0x7C→11, 0x39→12, 0x5E→13, 0x79→14, 0x71→15 decode as valid digits.
- Undefined: those six patterns are non-table and raise invalid_out.

## Test plan
- Reset, seg_in=0x3F held 10 cycles, STABLE_CYCLES=4 → single valid_out at the 4th edge after the first sample; digit_out=0, seq_err=0, period_out=0.
- Patterns 0,1,…,6,0 each held 100 cycles → 8 valid_out pulses, no seq_err, period_out=100 from the 2nd accept on.
- 0x3F stable, 0x06 for 2 cycles, then 0x3F → no valid_out and no invalid_out; digit_out stays 0.
- Sequence 2 then 5 → seq_err with valid_out, digit_out=5; then 6 → no seq_err.
- 0x77 stable → with SEG7_READER_HEX_EN: digit_out=10 with seq_err. Without: invalid_out pulse, digit_out unchanged.
- PERIOD_W=8: hold one digit 300 cycles → stall high after 255 cycles; next digit gives period_out=255 and stall cleared. Then assert rst mid-hold → all outputs 0, and re-accept in IDLE without seq_err.
